run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameters: RESET_CYCLES, 4, core reset hold length; TIMEOUT_CYCLES, 900000, watchdog limit in RUN; SIG_ADDR, 32'h8004, signature store address; HALT_ADDR, 32'h8008, halt store address; HALT_VALUE, 32'hCAFECAFE, halt store data; FIFO_DEPTH, 8, signature buffer entries (power of 2).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state on rising edge.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  single-cycle run request.
REQ-006 core_reset  out  1  reset to datapath.
REQ-007 core_en  out  1  enable to datapath.
REQ-008 rvfi_valid  in  1  retire strobe from datapath.
REQ-009 rvfi_mem_addr  in  32  retired store address.
REQ-010 rvfi_mem_wmask  in  4  retired store byte mask.
REQ-011 rvfi_mem_wdata  in  32  retired store data.
REQ-012 sig_valid  out  1; sig_data  out  32; sig_ready  in  1: signature stream, valid/ready.
REQ-013 done  out  1, halted and drained; timeout  out  1, watchdog expired; sig_overflow  out  1, sticky drop flag; retired_count  out  32, retires this run.

Function
REQ-014 FSM states IDLE, RESET_HOLD, RUN, DRAIN, DONE, TIMEOUT.
REQ-015 IDLE: core_reset=1, core_en=0; start -> RESET_HOLD.
REQ-016 RESET_HOLD: core_reset=1, core_en=0 for exactly RESET_CYCLES cycles, then -> RUN.
REQ-017 Entry to RESET_HOLD clears FIFO, watchdog, retired_count, sig_overflow, done, timeout.
REQ-018 RUN: core_reset=0, core_en=1; retired_count += 1 per rvfi_valid, saturating at 32'hFFFFFFFF.
REQ-019 Signature push: RUN and rvfi_valid and wmask==4'b1111 and addr==SIG_ADDR; wdata appears on sig_data with sig_valid=1 the next cycle (first-word-fall-through).
REQ-020 Halt: RUN and rvfi_valid and wmask==4'b1111 and addr==HALT_ADDR and wdata==HALT_VALUE -> DRAIN; other wmask or data at HALT_ADDR ignored.
REQ-021 Watchdog counts RUN cycles; after TIMEOUT_CYCLES cycles in RUN -> TIMEOUT; halt in the same cycle wins.
REQ-022 DRAIN: core_en=0, core_reset=0; stays until FIFO empty, then -> DONE; no pushes.
REQ-023 DONE: done=1, core_en=0; TIMEOUT: timeout=1, core_en=0, FIFO still drains; in both, start -> RESET_HOLD.
REQ-024 start ignored in RESET_HOLD, RUN, DRAIN.
REQ-025 Pop when sig_valid and sig_ready; push to full FIFO drops data and sets sig_overflow, unless pop occurs same cycle (then push accepted).
REQ-026 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-027 Reset -> IDLE; core_reset=1, core_en=0, sig_valid=0, sig_data=0, done=0, timeout=0, sig_overflow=0, retired_count=0, FIFO empty.
REQ-028 Reset mid-run overrides everything in the same edge; buffered signatures discarded.

Structure
REQ-029 FSM state enum and default address/value constants in shared package run_ctrl_pkg.
REQ-030 FIFO in sub-module sig_fifo (parameterized width/depth, FWFT, full/empty outputs).

Verification
REQ-031 Reset, start at cycle 0 -> core_reset=1 for 4 cycles, then core_en=1 on cycle 5.
REQ-032 Stores 0x11111111, 0x22222222 to 0x8004, sig_ready=1 -> sig_data emits both in order, one cycle after each retire.
REQ-033 Store 0xCAFECAFE to 0x8008 with 2 entries held (sig_ready=0) -> DRAIN, core_en=0; raise sig_ready -> 2 pops, then done=1.
REQ-034 9 signature stores, sig_ready=0, depth 8 -> 8 entries kept, sig_overflow=1; 0xDEADBEEF at 0x8008 or wmask 4'b0011 -> no halt.
REQ-035 TIMEOUT_CYCLES=20, no halt -> timeout=1 after 20 RUN cycles; halt on cycle 20 -> done path instead.
REQ-036 Reset asserted in RUN with 3 entries -> IDLE, sig_valid=0, retired_count=0 next cycle.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state enum, default addresses and helpers for run_controller
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    localparam logic [31:0] DEF_SIG_ADDR   = 32'h0000_8004;
    localparam logic [31:0] DEF_HALT_ADDR  = 32'h0000_8008;
    localparam logic [31:0] DEF_HALT_VALUE = 32'hCAFE_CAFE;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - retire bus from the datapath and signature stream out
interface run_controller_if;
    logic        rvfi_valid;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_wdata;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        sig_ready;

    modport slave (
        input  rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata, sig_ready,
        output sig_valid, sig_data
    );

    modport master (
        output rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata, sig_ready,
        input  sig_valid, sig_data
    );
endinterface

// File: rtl/run_controller_sig_fifo.sv
// rtl/run_controller_sig_fifo.sv - first-word-fall-through signature buffer
module sig_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        // a full buffer still takes a write when the head leaves in the same cycle
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - sequences datapath reset/run, collects signature stores, detects halt and watchdog expiry
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 900000,
    parameter logic [31:0] SIG_ADDR       = DEF_SIG_ADDR,
    parameter logic [31:0] HALT_ADDR      = DEF_HALT_ADDR,
    parameter logic [31:0] HALT_VALUE     = DEF_HALT_VALUE,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            start,
    output logic            core_reset,
    output logic            core_en,
    run_controller_if.slave bus,
    output logic            done,
    output logic            timeout,
    output logic            sig_overflow,
    output logic [31:0]     retired_count
);
    state_e      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] retired_q, retired_d;
    logic        overflow_q, overflow_d;
    logic        in_run, store_full, sig_push, halt_req, enter_hold;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_rd_data;

    always_comb begin
        in_run     = (state_q == ST_RUN);
        store_full = bus.rvfi_valid && (bus.rvfi_mem_wmask == 4'b1111);
        sig_push   = in_run && store_full && (bus.rvfi_mem_addr == SIG_ADDR);
        halt_req   = in_run && store_full && (bus.rvfi_mem_addr == HALT_ADDR)
                     && (bus.rvfi_mem_wdata == HALT_VALUE);
        enter_hold = start && ((state_q == ST_IDLE) || (state_q == ST_DONE)
                     || (state_q == ST_TIMEOUT));
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        retired_d  = retired_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (enter_hold) state_d = ST_RESET_HOLD;
            end
            ST_RESET_HOLD: begin
                if (hold_cnt_q == 32'(RESET_CYCLES - 1)) state_d = ST_RUN;
                else hold_cnt_d = hold_cnt_q + 32'd1;
            end
            ST_RUN: begin
                if (bus.rvfi_valid) retired_d = sat_inc(retired_q);
                wd_cnt_d = wd_cnt_q + 32'd1;
                // halt takes priority over a watchdog expiring on the same cycle
                if (halt_req) state_d = ST_DRAIN;
                else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) state_d = ST_TIMEOUT;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_hold) begin
            hold_cnt_d = '0;
            wd_cnt_d   = '0;
            retired_d  = '0;
            overflow_d = 1'b0;
        end
        if (sig_push && fifo_full && !bus.sig_ready) overflow_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            wd_cnt_q   <= '0;
            retired_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
        end
    end

    sig_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_sig_fifo (
        .clk       (CLK),
        .rst       (Reset),
        .clear     (enter_hold),
        .push      (sig_push),
        .push_data (bus.rvfi_mem_wdata),
        .pop       (bus.sig_ready),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign core_reset    = (state_q == ST_IDLE) || (state_q == ST_RESET_HOLD);
    assign core_en       = in_run;
    assign done          = (state_q == ST_DONE);
    assign timeout       = (state_q == ST_TIMEOUT);
    assign sig_overflow  = overflow_q;
    assign retired_count = retired_q;
    assign bus.sig_valid = !fifo_empty;
    assign bus.sig_data  = fifo_rd_data;

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - directed and randomized checks of run_controller against a queue-based model
module tb_run_controller;
    localparam int          RST_CYC = 4;
    localparam int          TMO     = 20;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] SIG_A   = 32'h8004;
    localparam logic [31:0] HALT_A  = 32'h8008;
    localparam logic [31:0] HALT_V  = 32'hCAFECAFE;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        core_reset, core_en, done, timeout, sig_overflow;
    logic [31:0] retired_count;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    run_controller_if bus();

    run_controller #(
        .RESET_CYCLES   (RST_CYC),
        .TIMEOUT_CYCLES (TMO),
        .SIG_ADDR       (SIG_A),
        .HALT_ADDR      (HALT_A),
        .HALT_VALUE     (HALT_V),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .start         (start),
        .core_reset    (core_reset),
        .core_en       (core_en),
        .bus           (bus.slave),
        .done          (done),
        .timeout       (timeout),
        .sig_overflow  (sig_overflow),
        .retired_count (retired_count)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        bus.rvfi_valid     = 1'b0;
        bus.rvfi_mem_addr  = '0;
        bus.rvfi_mem_wmask = '0;
        bus.rvfi_mem_wdata = '0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        bus.rvfi_valid     = 1'b1;
        bus.rvfi_mem_addr  = a;
        bus.rvfi_mem_wmask = m;
        bus.rvfi_mem_wdata = d;
        step();
        idle_bus();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        start = 1'b0;
        bus.sig_ready = 1'b0;
        idle_bus();
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RST_CYC) step();
    endtask

    task automatic drain_collect(output bit ok);
        got_q.delete();
        bus.sig_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.sig_valid) got_q.push_back(bus.sig_data);
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.sig_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_reset, core_en, bus.sig_valid, done, timeout, sig_overflow} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b want 100000",
                     {core_reset, core_en, bus.sig_valid, done, timeout, sig_overflow});
        end
        checks++;
        if (bus.sig_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_sig_data got %h want 0", bus.sig_data);
        end
        checks++;
        if (retired_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_retired got %0d want 0", retired_count);
        end
    endtask

    task automatic test_reset_hold();
        do_reset();
        start = 1'b1;
        for (int i = 1; i <= RST_CYC; i++) begin
            step();
            checks++;
            if ({core_reset, core_en} !== 2'b10) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b want 10", i, {core_reset, core_en});
            end
        end
        step();
        checks++;
        if ({core_reset, core_en} !== 2'b01) begin
            errors++;
            $display("FAIL hold_to_run got %b want 01", {core_reset, core_en});
        end
        step();
        start = 1'b0;
        checks++;
        if ({core_reset, core_en} !== 2'b01) begin
            errors++;
            $display("FAIL start_ignored_in_run got %b want 01", {core_reset, core_en});
        end
    endtask

    task automatic test_sig_stream();
        do_reset();
        start_run();
        bus.sig_ready = 1'b1;
        drive(SIG_A, 4'hF, 32'h11111111);
        checks++;
        if ({bus.sig_valid, bus.sig_data} !== {1'b1, 32'h11111111}) begin
            errors++;
            $display("FAIL stream_first got %b/%h want 1/11111111", bus.sig_valid, bus.sig_data);
        end
        drive(SIG_A, 4'hF, 32'h22222222);
        checks++;
        if ({bus.sig_valid, bus.sig_data} !== {1'b1, 32'h22222222}) begin
            errors++;
            $display("FAIL stream_second got %b/%h want 1/22222222", bus.sig_valid, bus.sig_data);
        end
        step();
        checks++;
        if (bus.sig_valid !== 1'b0 || retired_count !== 32'd2) begin
            errors++;
            $display("FAIL stream_empty got valid=%b retired=%0d want 0/2", bus.sig_valid, retired_count);
        end
        bus.sig_ready = 1'b0;
    endtask

    task automatic test_halt_drain();
        logic [31:0] d0, d1;
        bit ok;
        d0 = $urandom;
        d1 = $urandom;
        do_reset();
        start_run();
        drive(SIG_A, 4'hF, d0);
        drive(SIG_A, 4'hF, d1);
        drive(HALT_A, 4'hF, HALT_V);
        checks++;
        if ({core_en, core_reset, done, bus.sig_valid} !== 4'b0001 || bus.sig_data !== d0) begin
            errors++;
            $display("FAIL drain_entry got %b/%h want 0001/%h",
                     {core_en, core_reset, done, bus.sig_valid}, bus.sig_data, d0);
        end
        drain_collect(ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++;
            $display("FAIL drain_done got done=%0d pops=%0d want 1/2", ok, got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== d0 || got_q[1] !== d1) begin
                errors++;
                $display("FAIL drain_order got %h %h want %h %h", got_q[0], got_q[1], d0, d1);
            end
        end
        checks++;
        if (retired_count !== 32'd3) begin
            errors++;
            $display("FAIL drain_retired got %0d want 3", retired_count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d [9];
        bit ok;
        do_reset();
        start_run();
        for (int i = 0; i < 9; i++) begin
            d[i] = $urandom;
            drive(SIG_A, 4'hF, d[i]);
            if (i == DEPTH - 1) begin
                checks++;
                if (sig_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_full got %b want 0", sig_overflow);
                end
            end
        end
        checks++;
        if (sig_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b want 1", sig_overflow);
        end
        drive(HALT_A, 4'hF, 32'hDEADBEEF);
        drive(HALT_A, 4'b0011, HALT_V);
        checks++;
        if (core_en !== 1'b1) begin
            errors++;
            $display("FAIL no_halt got core_en=%b want 1", core_en);
        end
        drive(HALT_A, 4'hF, HALT_V);
        drain_collect(ok);
        checks++;
        if (!ok || got_q.size() != DEPTH) begin
            errors++;
            $display("FAIL ovf_kept got done=%0d entries=%0d want 1/%0d", ok, got_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (got_q[i] !== d[i]) begin
                    errors++;
                    $display("FAIL ovf_entry%0d got %h want %h", i, got_q[i], d[i]);
                end
            end
        end
        start_run();
        checks++;
        if ({sig_overflow, done, bus.sig_valid, core_en} !== 4'b0001 || retired_count !== 32'd0) begin
            errors++;
            $display("FAIL restart_clear got %b/%0d want 0001/0",
                     {sig_overflow, done, bus.sig_valid, core_en}, retired_count);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] x;
        x = $urandom;
        do_reset();
        start_run();
        drive(SIG_A, 4'hF, x);
        repeat (TMO - 2) step();
        checks++;
        if ({core_en, timeout} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_before got %b want 10", {core_en, timeout});
        end
        step();
        checks++;
        if ({core_en, timeout, done} !== 3'b010) begin
            errors++;
            $display("FAIL tmo_fire got %b want 010", {core_en, timeout, done});
        end
        checks++;
        if ({bus.sig_valid, bus.sig_data} !== {1'b1, x}) begin
            errors++;
            $display("FAIL tmo_held got %b/%h want 1/%h", bus.sig_valid, bus.sig_data, x);
        end
        bus.sig_ready = 1'b1;
        step();
        bus.sig_ready = 1'b0;
        checks++;
        if (bus.sig_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drain got %b want 0", bus.sig_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({timeout, core_reset} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_restart got %b want 01", {timeout, core_reset});
        end
    endtask

    task automatic test_halt_at_limit();
        do_reset();
        start_run();
        repeat (TMO - 1) step();
        drive(HALT_A, 4'hF, HALT_V);
        checks++;
        if ({core_en, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL halt_wins got %b want 00", {core_en, timeout});
        end
        step();
        checks++;
        if ({done, timeout} !== 2'b10) begin
            errors++;
            $display("FAIL halt_wins_done got %b want 10", {done, timeout});
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start_run();
        for (int i = 0; i < 3; i++) drive(SIG_A, 4'hF, $urandom);
        checks++;
        if (bus.sig_valid !== 1'b1 || retired_count !== 32'd3) begin
            errors++;
            $display("FAIL midrun_pre got %b/%0d want 1/3", bus.sig_valid, retired_count);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if ({bus.sig_valid, core_reset, core_en} !== 3'b010 || bus.sig_data !== 32'h0
            || retired_count !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset got %b/%h/%0d want 010/0/0",
                     {bus.sig_valid, core_reset, core_en}, bus.sig_data, retired_count);
        end
    endtask

    task automatic test_back_to_back();
        int          mode;
        int          run_cyc;
        int          sz;
        logic [31:0] exp_ret;
        logic        exp_ovf;
        logic [31:0] head;
        logic [68:0] expv, obsv;
        logic        popped, full_store, push, halt;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            start_run();
            exp_q.delete();
            exp_ret = 0;
            exp_ovf = 0;
            mode    = 0;
            run_cyc = 0;
            for (int c = 0; c < 60; c++) begin
                int sel;
                sel = $urandom_range(0, 3);
                bus.rvfi_valid     = ($urandom_range(0, 3) != 0);
                bus.rvfi_mem_addr  = (sel < 2) ? SIG_A : (sel == 2) ? HALT_A : (32'h9000 | $urandom_range(0, 255));
                bus.rvfi_mem_wmask = ($urandom_range(0, 3) == 0) ? 4'b0011 : 4'hF;
                bus.rvfi_mem_wdata = (sel == 2 && $urandom_range(0, 3) == 0) ? HALT_V : $urandom;
                bus.sig_ready      = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
                sz   = exp_q.size();
                head = 32'h0;
                if (sz > 0) head = exp_q[0];
                expv = {sz > 0, head, mode == 0, mode == 2, mode == 3, exp_ovf, exp_ret};
                obsv = {bus.sig_valid, bus.sig_data, core_en, done, timeout, sig_overflow, retired_count};
                checks++;
                if (obsv !== expv) begin
                    errors++;
                    $display("FAIL random_r%0d_c%0d got %h want %h", r, c, obsv, expv);
                end
                popped     = bus.sig_ready && (sz > 0);
                full_store = bus.rvfi_valid && (bus.rvfi_mem_wmask == 4'hF);
                push       = (mode == 0) && full_store && (bus.rvfi_mem_addr == SIG_A);
                halt       = (mode == 0) && full_store && (bus.rvfi_mem_addr == HALT_A)
                             && (bus.rvfi_mem_wdata == HALT_V);
                if (popped) void'(exp_q.pop_front());
                if (push) begin
                    if (sz < DEPTH || popped) exp_q.push_back(bus.rvfi_mem_wdata);
                    else exp_ovf = 1'b1;
                end
                if (mode == 0) begin
                    if (bus.rvfi_valid) exp_ret = exp_ret + 1;
                    run_cyc++;
                    if (halt) mode = 1;
                    else if (run_cyc == TMO) mode = 3;
                end else if (mode == 1 && sz == 0) begin
                    mode = 2;
                end
                step();
            end
            idle_bus();
            bus.sig_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        bus.sig_ready = 1'b0;
        test_reset();
        test_reset_hold();
        test_sig_stream();
        test_halt_drain();
        test_overflow();
        test_timeout();
        test_halt_at_limit();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
